controlador_divisor: RTL and testbench
======================================

CONTROLADOR_DIVISOR -- requirements
Module: controlador_divisor

Interface
REQ-001 Parameter NCH, default 4: number of tick channels sharing one prescaler.
REQ-002 Parameter DIV_BASE, default 50000: clki cycles per base tick; legal range 2..2^25-1.
REQ-003 Parameter WPER, default 16: channel period width in base ticks.
REQ-004 clki  in  1  single clock; one clock, all state on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 habilita  in  1  global enable; low freezes the prescaler and all channel counters.
REQ-007 cfg_valid  in  1  configuration request.
REQ-008 cfg_ready  out  1  controller can accept configuration.
REQ-009 cfg_ch  in  log2(NCH)  target channel.
REQ-010 cfg_periodo  in  WPER  period in base ticks; 0 means stop.
REQ-011 cfg_modo  in  1  0 = periodic, 1 = one-shot.
REQ-012 tick_base  out  1  one-cycle pulse per base tick.
REQ-013 tick  out  NCH  one-cycle pulse per channel expiry.
REQ-014 ocupado  out  NCH  channel active.

Function
REQ-015 Prescaler counts 0..DIV_BASE-1 while habilita=1, wraps to 0, holds while habilita=0.
REQ-016 tick_base is registered and high for exactly one cycle, in the cycle after the prescaler reads DIV_BASE-1.
REQ-017 Config FSM states: ESPERA, where cfg_ready=1, and APLICA, where cfg_ready=0.
REQ-018 ESPERA moves to APLICA on cfg_valid&cfg_ready; cfg_ch, cfg_periodo and cfg_modo are latched on that edge.
REQ-019 APLICA returns to ESPERA unconditionally after one cycle; each transaction costs 2 cycles, and cfg_valid held high is accepted again in the next ESPERA cycle.
REQ-020 On the APLICA edge with latched periodo≠0: channel counter loads periodo, modo is stored, ocupado[ch] is set.
REQ-021 On the APLICA edge with latched periodo=0: ocupado[ch] is cleared, the counter is cleared, and tick[ch] stays 0.
REQ-022 On each base-tick edge, every active channel other than the one being applied decrements.
REQ-023 A channel whose counter reads 1 on a base-tick edge pulses tick[i] in the same cycle as tick_base.
REQ-024 After that expiry, a periodic channel reloads its stored period.
REQ-025 After that expiry, a one-shot channel clears ocupado[i] on the same edge.
REQ-026 The first tick occurs on the periodo-th base tick after the APLICA cycle; periodo=1 ticks on every base tick.
REQ-027 Collision: if APLICA and a base tick hit the same channel on the same edge, configuration wins; no decrement, no tick.
REQ-028 Reconfiguring a running channel restarts it from the new period; the old count is discarded.
REQ-029 Inactive channels hold their counter and never tick.
REQ-030 habilita=0 suppresses tick_base and tick.
REQ-031 With habilita=0, the config handshake still operates and APLICA still loads the channel.
REQ-032 All outputs are registered except cfg_ready, which decodes the state register.

Reset
REQ-033 rstn=0 asynchronously forces: prescaler 0, FSM ESPERA (cfg_ready=1), all counters 0, ocupado=0, tick=0, tick_base=0.
REQ-034 Reset mid-operation, including during APLICA, discards the pending configuration; no tick occurs until a new configuration is applied.
REQ-035 After rstn rises with habilita=1, the first tick_base occurs DIV_BASE cycles later.

Structure
REQ-036 Package controlador_divisor_pkg holds: FSM state enum, MODO_PERIODICO/MODO_UNICO constants, and default NCH/WPER/DIV_BASE.
REQ-037 The prescaler is sub-module prescaler_base (DIV_BASE parameter, habilita in, tick out).
REQ-038 Channel logic is a generate loop inside controlador_divisor.

Verification (DIV_BASE=4, NCH=4, WPER=16)
REQ-039 Reset/base: hold rstn low 3 cycles, then release with habilita=1 -> tick=0, ocupado=0, cfg_ready=1 during reset; tick_base high at cycles 4, 8, 12 after release.
REQ-040 Periodic: cfg ch0, periodo=3, modo=0 -> ocupado[0]=1 after APLICA; tick[0] coincides with the 3rd tick_base, then every 12 cycles.
REQ-041 One-shot: cfg ch2, periodo=2, modo=1 -> single tick[2] on the 2nd base tick, with ocupado[2] falling on the same edge; no further ticks over 40 cycles.
REQ-042 Collision: ch1 running, counter 1; apply periodo=5 so that APLICA coincides with a base tick -> no tick[1] that cycle; next tick[1] 5 base ticks later.
REQ-043 Stop/handshake: cfg_valid held high for two back-to-back requests -> cfg_ready pattern 1,0,1,0; second request periodo=0 on ch0 -> ocupado[0]=0 and no further tick[0].
REQ-044 Reset mid-op: assert rstn during APLICA with ch3 running -> all outputs are at reset values immediately and ch3 stays silent after release.

Source files
------------

// File: rtl/controlador_divisor_pkg.sv
// Shared constants and types for the multi-channel tick controller.
// Holds the config FSM encoding, channel mode values and default sizing.
package controlador_divisor_pkg;

    localparam int unsigned NCH_DEF      = 4;
    localparam int unsigned WPER_DEF     = 16;
    localparam int unsigned DIV_BASE_DEF = 50000;

    typedef logic [0:0] estado_t;

    localparam estado_t ESPERA = 1'b0;
    localparam estado_t APLICA = 1'b1;

    localparam logic MODO_PERIODICO = 1'b0;
    localparam logic MODO_UNICO     = 1'b1;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ancho_ch(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prescaler_base.sv
// Free-running base-tick prescaler: counts 0..DIV_BASE-1 while enabled.
// fin_c flags the wrap edge so channels can act in the same cycle tick is set.
module prescaler_base
    import controlador_divisor_pkg::*;
#(
    parameter int unsigned DIV_BASE = DIV_BASE_DEF
) (
    input  logic clki,
    input  logic rstn,
    input  logic habilita,
    output logic tick,
    output logic fin_c
);

    localparam int unsigned WCNT = $clog2(DIV_BASE);

    logic [WCNT-1:0] cuenta;

    assign fin_c = habilita && (cuenta == WCNT'(DIV_BASE - 1));

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            cuenta <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= fin_c;
            if (fin_c) begin
                cuenta <= '0;
            end else if (habilita) begin
                cuenta <= cuenta + WCNT'(1);
            end
        end
    end

endmodule

// File: rtl/controlador_divisor.sv
// NCH programmable tick channels driven by one shared base-tick prescaler.
// A two-state handshake latches a channel config and applies it the next cycle.
module controlador_divisor
    import controlador_divisor_pkg::*;
#(
    parameter  int unsigned NCH      = NCH_DEF,
    parameter  int unsigned DIV_BASE = DIV_BASE_DEF,
    parameter  int unsigned WPER     = WPER_DEF,
    localparam int unsigned WCH      = ancho_ch(NCH)
) (
    input  logic            clki,
    input  logic            rstn,
    input  logic            habilita,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [WCH-1:0]  cfg_ch,
    input  logic [WPER-1:0] cfg_periodo,
    input  logic            cfg_modo,
    output logic            tick_base,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  ocupado
);

    estado_t         estado;
    estado_t         estado_sig;
    logic            acepta_c;
    logic            aplica_c;
    logic            fin_c;
    logic [WCH-1:0]  lat_ch;
    logic [WPER-1:0] lat_per;
    logic            lat_modo;

    prescaler_base #(
        .DIV_BASE (DIV_BASE)
    ) u_prescaler (
        .clki     (clki),
        .rstn     (rstn),
        .habilita (habilita),
        .tick     (tick_base),
        .fin_c    (fin_c)
    );

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA:  if (cfg_valid) estado_sig = APLICA;
            APLICA:  estado_sig = ESPERA;
            default: estado_sig = ESPERA;
        endcase
    end

    assign cfg_ready = (estado == ESPERA);
    assign acepta_c  = cfg_valid && cfg_ready;
    assign aplica_c  = (estado == APLICA);

    // Request is captured on acceptance and consumed on the APLICA edge.
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            lat_ch   <= '0;
            lat_per  <= '0;
            lat_modo <= MODO_PERIODICO;
        end else if (acepta_c) begin
            lat_ch   <= cfg_ch;
            lat_per  <= cfg_periodo;
            lat_modo <= cfg_modo;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_canal
        logic [WPER-1:0] cuenta;
        logic [WPER-1:0] periodo;
        logic            modo;
        logic            activo;
        logic            pulso;
        logic            sel_c;

        assign sel_c       = aplica_c && (lat_ch == WCH'(gi));
        assign tick[gi]    = pulso;
        assign ocupado[gi] = activo;

        // Configuration has priority over a coincident base tick.
        always_ff @(posedge clki or negedge rstn) begin
            if (!rstn) begin
                cuenta  <= '0;
                periodo <= '0;
                modo    <= MODO_PERIODICO;
                activo  <= 1'b0;
                pulso   <= 1'b0;
            end else begin
                pulso <= 1'b0;
                if (sel_c) begin
                    if (lat_per != '0) begin
                        cuenta  <= lat_per;
                        periodo <= lat_per;
                        modo    <= lat_modo;
                        activo  <= 1'b1;
                    end else begin
                        cuenta  <= '0;
                        activo  <= 1'b0;
                    end
                end else if (fin_c && activo) begin
                    if (cuenta == WPER'(1)) begin
                        pulso <= 1'b1;
                        if (modo == MODO_UNICO) begin
                            cuenta <= '0;
                            activo <= 1'b0;
                        end else begin
                            cuenta <= periodo;
                        end
                    end else begin
                        cuenta <= cuenta - WPER'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_controlador_divisor.sv
// Directed bench for controlador_divisor with DIV_BASE=4, NCH=4, WPER=16.
module tb_controlador_divisor;

    localparam int unsigned NCH  = 4;
    localparam int unsigned DIVB = 4;
    localparam int unsigned WPER = 16;

    logic            clki = 1'b0;
    logic            rstn;
    logic            habilita;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_ch;
    logic [WPER-1:0] cfg_periodo;
    logic            cfg_modo;
    logic            tick_base;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  ocupado;

    int total = 0;
    int bad   = 0;

    always #5 clki = ~clki;

    controlador_divisor #(
        .NCH      (NCH),
        .DIV_BASE (DIVB),
        .WPER     (WPER)
    ) dut (
        .clki        (clki),
        .rstn        (rstn),
        .habilita    (habilita),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_periodo (cfg_periodo),
        .cfg_modo    (cfg_modo),
        .tick_base   (tick_base),
        .tick        (tick),
        .ocupado     (ocupado)
    );

    typedef struct {
        logic            vld;
        logic [1:0]      ch;
        logic [WPER-1:0] per;
        logic            modo;
        logic            tb;
        logic [3:0]      tk;
        logic [3:0]      oc;
        logic            rdy;
    } vec_t;

    vec_t vt[60];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0h exp=%0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clki);
        @(negedge clki);
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [WPER-1:0] per, input logic m);
        cfg_valid   = v;
        cfg_ch      = ch;
        cfg_periodo = per;
        cfg_modo    = m;
    endtask

    // Advance until tick_base is seen, bounded to two prescaler periods.
    task automatic sync_base(input int idx);
        int n;
        n = 0;
        while (tick_base !== 1'b1 && n < 2 * DIVB) begin
            cyc();
            n++;
        end
        chk("sync_base", idx, 32'(tick_base), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        for (int r = 1; r <= 60; r++) begin
            vt[r-1].vld  = (r == 1) || (r == 13);
            vt[r-1].ch   = (r == 13) ? 2'd2 : 2'd0;
            vt[r-1].per  = (r == 13) ? 16'd2 : 16'd3;
            vt[r-1].modo = (r == 13);
            vt[r-1].tb   = (r % 4 == 0);
            vt[r-1].tk   = {1'b0, (r == 20), 1'b0, (r % 12 == 0)};
            vt[r-1].oc   = {1'b0, (r >= 14 && r < 20), 1'b0, (r >= 2)};
            vt[r-1].rdy  = !((r == 1) || (r == 13));
        end

        rstn     = 1'b1;
        habilita = 1'b1;
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        #2 rstn  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clki);
            chk("rst_tick", i, 32'(tick), 32'd0);
            chk("rst_ocupado", i, 32'(ocupado), 32'd0);
            chk("rst_ready", i, 32'(cfg_ready), 32'd1);
            chk("rst_tick_base", i, 32'(tick_base), 32'd0);
        end
        rstn = 1'b1;

        // Base ticks, periodic ch0 (periodo 3) and one-shot ch2 (periodo 2).
        for (int r = 0; r < 60; r++) begin
            drive(vt[r].vld, vt[r].ch, vt[r].per, vt[r].modo);
            cyc();
            chk("vec_tick_base", r + 1, 32'(tick_base), 32'(vt[r].tb));
            chk("vec_tick", r + 1, 32'(tick), 32'(vt[r].tk));
            chk("vec_ocupado", r + 1, 32'(ocupado), 32'(vt[r].oc));
            chk("vec_ready", r + 1, 32'(cfg_ready), 32'(vt[r].rdy));
        end
        drive(1'b0, 2'd0, 16'd0, 1'b0);

        // Collision: ch1 at periodo 1, reconfigured to 5 exactly on a base tick.
        sync_base(0);
        drive(1'b1, 2'd1, 16'd1, 1'b0);
        cyc();
        chk("col_ready", 0, 32'(cfg_ready), 32'd0);
        drive(1'b0, 2'd1, 16'd1, 1'b0);
        cyc();
        chk("col_ocupado1", 0, 32'(ocupado[1]), 32'd1);
        cyc();
        cyc();
        chk("col_pre_tick1", 0, 32'(tick[1]), 32'd1);
        cyc();
        cyc();
        drive(1'b1, 2'd1, 16'd5, 1'b0);
        cyc();
        chk("col_ready", 1, 32'(cfg_ready), 32'd0);
        drive(1'b0, 2'd1, 16'd5, 1'b0);
        cyc();
        chk("col_edge_base", 0, 32'(tick_base), 32'd1);
        chk("col_edge_tick1", 0, 32'(tick[1]), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("col_after_tick1", i, 32'(tick[1]), 32'(i == 20));
        end

        // Back-to-back handshake: start ch3, then stop ch0.
        chk("hs_ready", 0, 32'(cfg_ready), 32'd1);
        drive(1'b1, 2'd3, 16'd7, 1'b0);
        cyc();
        chk("hs_ready", 1, 32'(cfg_ready), 32'd0);
        drive(1'b1, 2'd0, 16'd0, 1'b0);
        cyc();
        chk("hs_ready", 2, 32'(cfg_ready), 32'd1);
        cyc();
        chk("hs_ready", 3, 32'(cfg_ready), 32'd0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        cyc();
        chk("hs_ready", 4, 32'(cfg_ready), 32'd1);
        chk("hs_ocupado0", 0, 32'(ocupado[0]), 32'd0);
        chk("hs_ocupado3", 0, 32'(ocupado[3]), 32'd1);
        n = (tick[0] === 1'b1) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (tick[0] !== 1'b0) n++;
        end
        chk("stop_tick0_count", 0, 32'(n), 32'd0);

        // Reset asserted while APLICA is pending.
        drive(1'b1, 2'd3, 16'd2, 1'b0);
        cyc();
        chk("rm_ready", 0, 32'(cfg_ready), 32'd0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("rm_tick", 0, 32'(tick), 32'd0);
        chk("rm_ocupado", 0, 32'(ocupado), 32'd0);
        chk("rm_tick_base", 0, 32'(tick_base), 32'd0);
        chk("rm_ready", 1, 32'(cfg_ready), 32'd1);
        cyc();
        cyc();
        rstn = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            chk("rm_base", i, 32'(tick_base), 32'(i % 4 == 0));
            if (tick !== 4'd0) n++;
        end
        chk("rm_silent", 0, 32'(n), 32'd0);
        chk("rm_ocupado_end", 0, 32'(ocupado), 32'd0);

        // Disabled: handshake still loads, but no ticks until re-enabled.
        habilita = 1'b0;
        drive(1'b1, 2'd2, 16'd1, 1'b0);
        cyc();
        chk("hab_ready", 0, 32'(cfg_ready), 32'd0);
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        cyc();
        chk("hab_ocupado", 0, 32'(ocupado), 32'h4);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (tick_base !== 1'b0 || tick !== 4'd0) n++;
        end
        chk("hab_frozen", 0, 32'(n), 32'd0);
        habilita = 1'b1;
        sync_base(1);
        chk("hab_resume_tick2", 0, 32'(tick[2]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
